tank_level_emulator: RTL and testbench
======================================

Name: tank_level_emulator

Overview:
- Plant-side model of the irrigation reservoir. It consumes the controller's valve commands (Ve fill, Bs sprinkler, Vs drip) and produces the tank level sensors H/M/L.
- Closes the loop for bench and board demos. The irrigation controller and display logic can be exercised without a physical tank.
- Level is an integer register updated on a prescaled tick. A region FSM derives the sensor outputs.

Parameters:
- CLK_DIV, 50000000, clock cycles per simulation tick (must be ≥2)
- LEVEL_W, 7, level register width
- LEVEL_MAX, 100, full-scale level (must be < 2^LEVEL_W)
- INIT_LEVEL, 0, level loaded on reset
- L_TH, 10, level at or above which L asserts
- M_TH, 50, level at or above which M asserts
- H_TH, 90, level at or above which H asserts
- FILL_RATE, 5, units added per tick while Ve=1
- BS_RATE, 3, units removed per tick while Bs=1
- VS_RATE, 1, units removed per tick while Vs=1
- HYST, 3, falling hysteresis band (used only with the optional feature)

Ports:
- clock, input, 1, system clock
- reset, input, 1, asynchronous active-high reset
- Ve, input, 1, inlet valve open
- Bs, input, 1, sprinkler pump on
- Vs, input, 1, drip valve open
- H, output, 1, high level sensor
- M, output, 1, mid level sensor
- L, output, 1, low level sensor
- level, output, LEVEL_W, current level
- tick, output, 1, one-cycle strobe on each update cycle
- overflow, output, 1, one-cycle pulse when fill is clipped at LEVEL_MAX
- dry, output, 1, one-cycle pulse when drain is clipped at 0

Behaviour:
- Reset values:
  - level=INIT_LEVEL.
  - Prescaler count=0.
  - tick=overflow=dry=0.
  - The region FSM is loaded directly from INIT_LEVEL using the rising thresholds, and H/M/L match it.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick=1 in the cycle where count==CLK_DIV-1.
  - The first tick occurs on the CLK_DIV-th rising edge after reset deasserts.
- On a tick cycle, Ve/Bs/Vs are sampled. Inputs on non-tick cycles are ignored (no latching).
- Arithmetic:
  - delta = (Ve?FILL_RATE:0) - (Bs?BS_RATE:0) - (Vs?VS_RATE:0), computed signed at LEVEL_W+2 bits.
  - sum = level + delta.
  - If sum > LEVEL_MAX: level=LEVEL_MAX and overflow=1.
  - If sum < 0: level=0 and dry=1.
  - Otherwise level=sum.
  - overflow and dry are registered and valid in the cycle after the tick, aligned with the new level.
- Boundary cases:
  - All valves closed, or delta=0: level is unchanged and no pulse is generated.
  - Ve=1 at LEVEL_MAX with net positive delta: overflow fires every tick while the condition holds.
  - Ve=1 together with drains: only the net delta matters. Example: Ve+Bs gives +2.
- Region FSM (states EMPTY, LOW, MID, FULL), evaluated on the updated level in the cycle after the tick:
  - Next region = highest region whose rising threshold ≤ level.
  - The FSM may jump several regions in one tick.
  - Outputs: L = (region≠EMPTY); M = (region∈{MID,FULL}); H = (region==FULL).
  - The sensor combination is always monotone, so the controller's E stays 0 with this model.
- H/M/L and level change in the same cycle. They are registered, with no combinational path from Ve/Bs/Vs.
- Reset mid-operation takes effect immediately:
  - All registers return to their reset values.
  - Any pending tick is discarded.
  - The prescaler restarts from 0.

Optional Feature:
- Macro: TANK_SENSOR_HYST_EN.
- Defined:
  - Rising transitions use L_TH/M_TH/H_TH unchanged.
  - A falling transition out of a region whose threshold is TH happens only when level < TH-HYST. Example: FULL→MID needs level < H_TH-HYST.
  - Multi-region drops evaluate each falling threshold with the same rule.
- Undefined:
  - Falling transitions use the plain thresholds (level < TH). The HYST parameter is unused.

Test Plan (CLK_DIV=4, other parameters default unless stated):
- Reset, then hold Ve=Bs=Vs=0 for 40 cycles -> level=0, H=M=L=0, tick pulses every 4 cycles, no overflow or dry pulses.
- Ve=1 from level 0 -> level 5 then 10:
  - L=1 in the same cycle level reaches 10.
  - M=1 at level 50 (tick 10).
  - H=1 at level 90 (tick 18).
  - Level 100 at tick 20.
  - Tick 21 gives overflow=1 for one cycle and level stays 100.
- Level 12, then Ve=0, Bs=1, Vs=1 (delta -4):
  - level 8, so L=0 (macro undefined).
  - level 4, then 0.
  - The next tick gives dry=1 and level stays 0.
- Level 40, then Ve=1 and Bs=1 (net +2) for 5 ticks -> level 50, M=1; no overflow or dry.
- With TANK_SENSOR_HYST_EN (HYST=3), level 12, delta -4 -> level 8 keeps L=1; level 4 gives L=0.
- Level 60 with Ve=1, reset pulsed for 1 cycle between ticks -> level=0 and H/M/L=0 immediately; next tick exactly 4 cycles after reset release.

Source files
------------

// File: rtl/tank_level_emulator.sv
// tank_level_emulator
//   Plant-side model of the irrigation reservoir. Integrates the controller's
//   valve commands into a level register on a prescaled tick and derives the
//   H/M/L level sensors from a region FSM.
//
//   Optional build macro: TANK_SENSOR_HYST_EN
//     When defined, falling region transitions require level < TH-HYST.
//     When undefined, falling transitions use the plain thresholds.
//
//   Ports:
//     clock    in   system clock
//     reset    in   asynchronous active-high reset
//     Ve       in   inlet valve open (fill)
//     Bs       in   sprinkler pump on (drain)
//     Vs       in   drip valve open (drain)
//     H/M/L    out  high / mid / low level sensors (registered)
//     level    out  current level, LEVEL_W bits
//     tick     out  one-cycle strobe on each update cycle
//     overflow out  one-cycle pulse when fill was clipped at LEVEL_MAX
//     dry      out  one-cycle pulse when drain was clipped at 0
module tank_level_emulator #(
  parameter int CLK_DIV    = 50000000,
  parameter int LEVEL_W    = 7,
  parameter int LEVEL_MAX  = 100,
  parameter int INIT_LEVEL = 0,
  parameter int L_TH       = 10,
  parameter int M_TH       = 50,
  parameter int H_TH       = 90,
  parameter int FILL_RATE  = 5,
  parameter int BS_RATE    = 3,
  parameter int VS_RATE    = 1,
  parameter int HYST       = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               Ve,
  input  logic               Bs,
  input  logic               Vs,
  output logic               H,
  output logic               M,
  output logic               L,
  output logic [LEVEL_W-1:0] level,
  output logic               tick,
  output logic               overflow,
  output logic               dry
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int SW    = LEVEL_W + 2;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [LEVEL_W-1:0] INIT_L   = LEVEL_W'(INIT_LEVEL);
  localparam logic [LEVEL_W-1:0] L_TH_L   = LEVEL_W'(L_TH);
  localparam logic [LEVEL_W-1:0] M_TH_L   = LEVEL_W'(M_TH);
  localparam logic [LEVEL_W-1:0] H_TH_L   = LEVEL_W'(H_TH);

`ifdef TANK_SENSOR_HYST_EN
  localparam int BAND = HYST;
`else
  // Plain thresholds: the falling band collapses to zero.
  localparam int BAND = HYST * 0;
`endif

  localparam int L_FALL = L_TH - BAND;
  localparam int M_FALL = M_TH - BAND;
  localparam int H_FALL = H_TH - BAND;

  typedef enum logic [1:0] {EMPTY, LOW, MID, FULL} region_t;

  // Highest region whose rising threshold is at or below the level.
  function automatic region_t rise_of(input logic [LEVEL_W-1:0] lv);
    region_t r;
    r = EMPTY;
    if (lv >= L_TH_L) r = LOW;
    if (lv >= M_TH_L) r = MID;
    if (lv >= H_TH_L) r = FULL;
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == CNT_LAST);

  // ---------------------------------------------------------------------
  // Level arithmetic
  // ---------------------------------------------------------------------
  logic signed [SW-1:0]  delta;
  logic signed [SW-1:0]  sum;
  logic [LEVEL_W-1:0]    level_next;
  logic                  clip_hi;
  logic                  clip_lo;

  always_comb begin
    delta = '0;
    if (Ve) delta = delta + SW'(FILL_RATE);
    if (Bs) delta = delta - SW'(BS_RATE);
    if (Vs) delta = delta - SW'(VS_RATE);
    sum = $signed({2'b00, level}) + delta;

    clip_hi    = 1'b0;
    clip_lo    = 1'b0;
    level_next = sum[LEVEL_W-1:0];
    if (sum[SW-1]) begin
      clip_lo    = 1'b1;
      level_next = '0;
    end else if (sum > $signed(SW'(LEVEL_MAX))) begin
      clip_hi    = 1'b1;
      level_next = LEVEL_W'(LEVEL_MAX);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level    <= INIT_L;
      overflow <= 1'b0;
      dry      <= 1'b0;
    end else begin
      overflow <= tick & clip_hi;
      dry      <= tick & clip_lo;
      if (tick) level <= level_next;
    end
  end

  // ---------------------------------------------------------------------
  // Region FSM
  // ---------------------------------------------------------------------
  region_t region;
  region_t region_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      region <= rise_of(INIT_L);
    end else begin
      region <= region_next;
    end
  end

  // The FSM looks at level_next so the region lands in the same cycle as
  // the level it describes. Falling steps are peeled off one region at a
  // time so a multi-region drop applies every falling threshold in turn.
  always_comb begin
    region_t rise;
    int      lv_i;
    region_next = region;
    rise        = rise_of(level_next);
    lv_i        = int'(level_next);
    if (tick) begin
      if (rise >= region) begin
        region_next = rise;
      end else begin
        if (region_next == FULL && lv_i < H_FALL) region_next = MID;
        if (region_next == MID  && lv_i < M_FALL) region_next = LOW;
        if (region_next == LOW  && lv_i < L_FALL) region_next = EMPTY;
      end
    end
  end

  always_comb begin
    L = (region != EMPTY);
    M = (region == MID) || (region == FULL);
    H = (region == FULL);
  end

endmodule

// File: tb/tb_tank_level_emulator.sv
module tb_tank_level_emulator;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       Ve = 1'b0;
  logic       Bs = 1'b0;
  logic       Vs = 1'b0;
  logic       H, M, L;
  logic [6:0] level;
  logic       tick, overflow, dry;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  tank_level_emulator #(.CLK_DIV(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .Ve       (Ve),
    .Bs       (Bs),
    .Vs       (Vs),
    .H        (H),
    .M        (M),
    .L        (L),
    .level    (level),
    .tick     (tick),
    .overflow (overflow),
    .dry      (dry)
  );

  // Reference sensor decode with plain rising thresholds.
  function automatic logic [2:0] hml_of(input int lv);
    return {lv >= 90, lv >= 50, lv >= 10};
  endfunction

  // Wait (bounded) for the tick cycle, then step past the update edge.
  task automatic do_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clock);
      if (tick) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL tick_timeout got tick=0 expected tick=1 within 8 cycles");
    end
    @(negedge clock);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] exp_v;
    Ve = 1'b0; Bs = 1'b0; Vs = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if ({tick, level, H, M, L, overflow, dry} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state got %b expected %b",
               {tick, level, H, M, L, overflow, dry}, 13'd0);
    end
    reset = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      exp_v = {((i % 4) == 3), 12'd0};
      checks++;
      if ({tick, level, H, M, L, overflow, dry} !== exp_v) begin
        errors++;
        $display("FAIL idle_cycle%0d got %b expected %b", i,
                 {tick, level, H, M, L, overflow, dry}, exp_v);
      end
    end
  endtask

  task automatic test_fill();
    int          lv;
    logic [11:0] exp_v;
    Ve = 1'b1;
    for (int t = 1; t <= 21; t++) begin
      do_tick();
      lv = (t * 5 > 100) ? 100 : t * 5;
      exp_v = {7'(lv), hml_of(lv), (t == 21), 1'b0};
      checks++;
      if ({level, H, M, L, overflow, dry} !== exp_v) begin
        errors++;
        $display("FAIL fill_tick%0d got %b expected %b", t,
                 {level, H, M, L, overflow, dry}, exp_v);
      end
    end
    @(negedge clock);
    checks++;
    if ({level, overflow} !== {7'd100, 1'b0}) begin
      errors++;
      $display("FAIL overflow_one_cycle got level=%0d ovf=%b expected level=100 ovf=0",
               level, overflow);
    end
    Ve = 1'b0;
    do_tick();
    checks++;
    if ({level, H, M, L, overflow, dry} !== {7'd100, 3'b111, 2'b00}) begin
      errors++;
      $display("FAIL closed_full got %b expected %b",
               {level, H, M, L, overflow, dry}, {7'd100, 3'b111, 2'b00});
    end
  endtask

  task automatic test_drain();
    logic exp_l8;
`ifdef TANK_SENSOR_HYST_EN
    exp_l8 = 1'b1;
`else
    exp_l8 = 1'b0;
`endif
    apply_reset();
    Ve = 1'b1;
    do_tick();
    do_tick();
    Bs = 1'b1;
    do_tick();
    checks++;
    if ({level, H, M, L} !== {7'd12, 3'b001}) begin
      errors++;
      $display("FAIL drain_setup got level=%0d hml=%b expected level=12 hml=001",
               level, {H, M, L});
    end
    Ve = 1'b0; Vs = 1'b1;
    do_tick();
    checks++;
    if ({level, L, dry} !== {7'd8, exp_l8, 1'b0}) begin
      errors++;
      $display("FAIL drain_8 got level=%0d L=%b dry=%b expected level=8 L=%b dry=0",
               level, L, dry, exp_l8);
    end
    do_tick();
    checks++;
    if ({level, H, M, L, dry} !== {7'd4, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL drain_4 got level=%0d hml=%b dry=%b expected level=4 hml=000 dry=0",
               level, {H, M, L}, dry);
    end
    do_tick();
    checks++;
    if ({level, dry} !== {7'd0, 1'b0}) begin
      errors++;
      $display("FAIL drain_0 got level=%0d dry=%b expected level=0 dry=0", level, dry);
    end
    do_tick();
    checks++;
    if ({level, dry, overflow} !== {7'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dry_pulse got level=%0d dry=%b ovf=%b expected level=0 dry=1 ovf=0",
               level, dry, overflow);
    end
    @(negedge clock);
    checks++;
    if (dry !== 1'b0) begin
      errors++;
      $display("FAIL dry_one_cycle got dry=%b expected dry=0", dry);
    end
    Bs = 1'b0; Vs = 1'b0;
  endtask

  task automatic test_net_fill();
    int          lv;
    logic [11:0] exp_v;
    apply_reset();
    Ve = 1'b1;
    for (int t = 1; t <= 8; t++) do_tick();
    checks++;
    if ({level, H, M, L} !== {7'd40, 3'b001}) begin
      errors++;
      $display("FAIL net_setup got level=%0d hml=%b expected level=40 hml=001",
               level, {H, M, L});
    end
    Bs = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      do_tick();
      lv = 40 + 2 * k;
      exp_v = {7'(lv), hml_of(lv), 2'b00};
      checks++;
      if ({level, H, M, L, overflow, dry} !== exp_v) begin
        errors++;
        $display("FAIL net_tick%0d got %b expected %b", k,
                 {level, H, M, L, overflow, dry}, exp_v);
      end
    end
    Ve = 1'b0; Bs = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    Ve = 1'b1;
    for (int t = 1; t <= 12; t++) do_tick();
    checks++;
    if ({level, H, M, L} !== {7'd60, 3'b011}) begin
      errors++;
      $display("FAIL mid_setup got level=%0d hml=%b expected level=60 hml=011",
               level, {H, M, L});
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({level, H, M, L, tick} !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset_async got level=%0d hml=%b tick=%b expected all 0",
               level, {H, M, L}, tick);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      checks++;
      if ({tick, level} !== {(i == 3), 7'd0}) begin
        errors++;
        $display("FAIL restart_cycle%0d got tick=%b level=%0d expected tick=%b level=0",
                 i, tick, level, (i == 3));
      end
    end
    @(negedge clock);
    checks++;
    if ({tick, level} !== {1'b0, 7'd5}) begin
      errors++;
      $display("FAIL restart_update got tick=%b level=%0d expected tick=0 level=5",
               tick, level);
    end
    Ve = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_net_fill();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
